dip_debounce: RTL and testbench

Conditions the raw PMOD DIP-switch byte before it reaches the nibble-to-seven-segment decoders. Each switch line is synchronised into `clk_16mhz`, debounced with its own stability counter, and presented as a clean registered byte. One-cycle rise, fall and change strobes let downstream logic react to switch edges without its own edge detection.

---
 rtl/dip_pkg.sv | 5 +
 rtl/dip_debounce_bit.sv | 66 ++++++
 rtl/dip_debounce.sv | 51 +++++
 tb/tb_dip_debounce.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dip_pkg.sv
// Shared constants for the DIP-switch conditioning path.
package dip_pkg;
  localparam int DEBOUNCE_10MS_16MHZ = 160000;
  localparam int SYNC_STAGES         = 2;
endpackage

// File: rtl/dip_debounce_bit.sv
// One switch line: 2-flop synchroniser, stability counter, debounced level
// and registered rise/fall strobes.
module debounce_bit
  import dip_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_10MS_16MHZ,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 3)
) (
  input  logic clk_16mhz,
  input  logic rst_n,
  input  logic raw,
  input  logic valid_q,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] r_sync;   // [0] = m, [SYNC_STAGES-1] = s
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_mismatch;
  logic                   w_accept;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_s != r_level);
  assign w_accept   = w_mismatch && (r_cnt == CNT_W'(STABLE_CYCLES - 1));

  // Shift the raw asynchronous level into the clock domain.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
  end

  // Count consecutive mismatches; any match discards the partial count.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!w_mismatch) begin
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_level <= w_s;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Strobes land in the same cycle the new level appears; startup flips
  // (before valid) are silent.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept &  w_s & valid_q;
      r_fall <= w_accept & ~w_s & valid_q;
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;
endmodule

// File: rtl/dip_debounce.sv
// Debounced PMOD DIP-switch byte with startup window and edge strobes.
module dip_debounce
  import dip_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = DEBOUNCE_10MS_16MHZ,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 3)
) (
  input  logic             clk_16mhz,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic             sw_valid,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);
  logic [CNT_W-1:0] r_start;
  logic             r_valid;

  // Startup window: valid on edge STABLE_CYCLES+2 after release, the same
  // edge on which lines already high at release are accepted.
  always_ff @(posedge clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= '0;
      r_valid <= 1'b0;
    end else if (!r_valid) begin
      r_start <= r_start + 1'b1;
      r_valid <= (r_start == CNT_W'(STABLE_CYCLES + 1));
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clk_16mhz (clk_16mhz),
      .rst_n     (rst_n),
      .raw       (sw_in[i]),
      .valid_q   (r_valid),
      .level     (sw_out[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  assign sw_valid = r_valid;
  // OR of registered strobes, so it is glitch-free and coincident with them.
  assign changed  = |(rise | fall);
endmodule

// File: tb/tb_dip_debounce.sv
// Scoreboarded bench for dip_debounce with STABLE_CYCLES=4.
module tb_dip_debounce;
  localparam int S = 4;
  localparam int W = 8;

  logic         clk_16mhz = 1'b0;
  logic         rst_n     = 1'b0;
  logic [W-1:0] sw_in     = '0;
  logic [W-1:0] sw_out, rise, fall;
  logic         sw_valid, changed;

  dip_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk_16mhz (clk_16mhz),
    .rst_n     (rst_n),
    .sw_in     (sw_in),
    .sw_out    (sw_out),
    .sw_valid  (sw_valid),
    .rise      (rise),
    .fall      (fall),
    .changed   (changed)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  typedef struct {
    logic [W-1:0] out;
    logic         valid;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   rise7_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: per line, the level two samples back must disagree with
  // the accepted level for S consecutive edges before it is taken.
  logic [W-1:0] m_out, dl0, dl1, seen, m_rise, m_fall;
  int           run [W];
  int           m_edges;
  logic         m_valid, vb;

  always @(posedge clk_16mhz) begin
    exp_t e;
    if (!rst_n) begin
      m_out = '0; dl0 = '0; dl1 = '0; m_valid = 1'b0; m_edges = 0;
      foreach (run[i]) run[i] = 0;
      m_rise = '0; m_fall = '0;
    end else begin
      seen = dl1; dl1 = dl0; dl0 = sw_in;
      vb = m_valid; m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (seen[i] != m_out[i]) begin
          run[i]++;
          if (run[i] == S) begin
            m_out[i] = seen[i];
            run[i]   = 0;
            if (vb) begin
              m_rise[i] = seen[i];
              m_fall[i] = ~seen[i];
            end
          end
        end else begin
          run[i] = 0;
        end
      end
      m_edges++;
      m_valid = (m_edges >= S + 2);
    end
    e.out = m_out; e.valid = m_valid; e.rise = m_rise; e.fall = m_fall;
    e.chg = |(m_rise | m_fall);
    exp_q.push_back(e);
  end

  // Monitor: one expectation per edge, compared mid-cycle.
  always @(negedge clk_16mhz) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sw_out",   32'(sw_out),   32'(e.out));
      check("sw_valid", 32'(sw_valid), 32'(e.valid));
      check("rise",     32'(rise),     32'(e.rise));
      check("fall",     32'(fall),     32'(e.fall));
      check("changed",  32'(changed),  32'(e.chg));
      if (rise[7] === 1'b1) rise7_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_16mhz);
  endtask

  initial begin
    // 1: switches high through reset
    sw_in = 8'hA5;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    check("startup_not_yet_valid", 32'(sw_valid), 32'd0);
    cyc(1);
    check("startup_out", 32'(sw_out), 32'hA5);
    check("startup_valid", 32'(sw_valid), 32'd1);
    cyc(4);

    // 2: clean rising edge from 00
    sw_in = 8'h00; cyc(10);
    sw_in = 8'h01; cyc(10);
    check("rise_out", 32'(sw_out), 32'h01);

    // 3: glitch on bit 3 shorter than S
    sw_in = 8'h00; cyc(10);
    sw_in = 8'h08; cyc(3);
    sw_in = 8'h00; cyc(10);
    check("glitch_out", 32'(sw_out), 32'h00);

    // 4: bounce on bit 7 then settle high
    rise7_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      sw_in[7] = (k % 2 == 0); cyc(2);
    end
    cyc(12);
    check("bounce_rise7_pulses", 32'(rise7_cnt), 32'd1);
    check("bounce_out", 32'(sw_out), 32'h80);

    // 5: opposite edges on both nibbles
    sw_in = 8'h0F; cyc(10);
    sw_in = 8'hF0; cyc(10);
    check("swap_out", 32'(sw_out), 32'hF0);

    // 6: reset while bit 0 counter is at 2
    sw_in = 8'h00; cyc(10);
    sw_in = 8'h01; cyc(4);
    #1 rst_n = 1'b0;
    #1;
    check("rst_sw_out",   32'(sw_out),   32'd0);
    check("rst_sw_valid", 32'(sw_valid), 32'd0);
    check("rst_strobes",  32'({rise, fall, 7'd0, changed}), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    check("restart_not_yet_valid", 32'(sw_valid), 32'd0);
    cyc(1);
    check("restart_valid", 32'(sw_valid), 32'd1);
    check("restart_out", 32'(sw_out), 32'h01);

    // Randomised holds and single-bit flips
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 0) sw_in = 8'($urandom);
      else sw_in[$urandom_range(0, W - 1)] ^= 1'b1;
      cyc($urandom_range(1, 9));
    end
    cyc(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
